asp_mmio_dfh_responder: RTL and testbench

Avalon-MM MMIO responder that terminates the 64-bit MMIO sink produced by the host-channel shim on each child host-memory link. It answers every host MMIO request with fixed read latency. It implements a child DFH, a GUID, scratch, control, status-counter and error registers, and drives a software-controlled soft-reset pulse into the child link's logic.

---
 rtl/ofs_asp_pkg.sv | 32 +++
 rtl/asp_pulse_stretch.sv | 34 +++
 rtl/asp_mmio_dfh_responder.sv | 121 ++++++++++++
 tb/tb_asp_mmio_dfh_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ofs_asp_pkg.sv
// +----------------------------------------------------------------------+
// | ofs_asp_pkg: register map, DFH packing and CTRL layout for the ASP    |
// | MMIO responder.                            Revision: 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

package ofs_asp_pkg;

  localparam logic [3:0] AFU_DFH_TYPE = 4'h1;

  localparam logic [5:0] OFF_DFH     = 6'h00;
  localparam logic [5:0] OFF_GUID_L  = 6'h08;
  localparam logic [5:0] OFF_GUID_H  = 6'h10;
  localparam logic [5:0] OFF_RSVD    = 6'h18;
  localparam logic [5:0] OFF_SCRATCH = 6'h20;
  localparam logic [5:0] OFF_CTRL    = 6'h28;
  localparam logic [5:0] OFF_STATUS  = 6'h30;
  localparam logic [5:0] OFF_ERR     = 6'h38;

  typedef struct packed {
    logic clr_cnt;
    logic soft_rst;
  } ctrl_t;

  function automatic logic [63:0] dfh_pack(input logic [11:0] id, input logic [3:0] rev,
                                           input logic [23:0] next, input logic eol);
    return {AFU_DFH_TYPE, 19'h0, eol, next, rev, id};
  endfunction

endpackage

`default_nettype wire

// File: rtl/asp_pulse_stretch.sv
// +----------------------------------------------------------------------+
// | asp_pulse_stretch: restartable down-counter producing a CYCLES-long   |
// | high pulse after each start strobe.        Revision: 1.0              |
// +----------------------------------------------------------------------+
`default_nettype none

module asp_pulse_stretch #(
  parameter int CYCLES = 16
) (
  input  logic afu_clk,
  input  logic afu_reset_n,
  input  logic start,
  output logic pulse
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge afu_clk or negedge afu_reset_n) begin
    if (!afu_reset_n) begin
      count <= '0;
    end else if (start) begin
      count <= CW'(CYCLES);
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign pulse = (count != '0);

endmodule

`default_nettype wire

// File: rtl/asp_mmio_dfh_responder.sv
// +----------------------------------------------------------------------+
// | asp_mmio_dfh_responder: fixed-latency 64-bit MMIO responder with DFH, |
// | GUID, scratch, control, counters and error.  Revision: 1.0            |
// +----------------------------------------------------------------------+
`default_nettype none

module asp_mmio_dfh_responder
  import ofs_asp_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 16,
  parameter logic [63:0] GUID_H          = 64'h0,
  parameter logic [63:0] GUID_L          = 64'h0,
  parameter logic [11:0] FEATURE_ID      = 12'h0,
  parameter logic [3:0]  FEATURE_REV     = 4'h0,
  parameter logic [23:0] NEXT_DFH_OFFSET = 24'h0,
  parameter logic        END_OF_LIST     = 1'b1,
  parameter int          SOFT_RST_CYCLES = 16
) (
  input  logic                  afu_clk,
  input  logic                  afu_reset_n,
  input  logic [ADDR_WIDTH-1:0] mmio_address,
  input  logic                  mmio_read,
  input  logic                  mmio_write,
  input  logic [63:0]           mmio_writedata,
  input  logic [7:0]            mmio_byteenable,
  output logic                  mmio_waitrequest,
  output logic [63:0]           mmio_readdata,
  output logic                  mmio_readdatavalid,
  output logic                  soft_reset
);

  logic        rd_acc, wr_acc, hit;
  logic [5:0]  offset;
  ctrl_t       ctrl_wr, ctrl_rd;
  logic        soft_start, clr_cnt, ctrl_hit, err_clr;
  logic [63:0] scratch, rd_mux, data_s1;
  logic [31:0] wr_cnt, rd_cnt;
  logic        err, valid_s1;

  assign rd_acc   = mmio_read  & ~mmio_waitrequest;
  assign wr_acc   = mmio_write & ~mmio_waitrequest;
  assign hit      = (mmio_address >> 3) == '0;
  assign offset   = {mmio_address[2:0], 3'b000};
  assign ctrl_wr  = ctrl_t'(mmio_writedata[1:0]);
  assign ctrl_hit = wr_acc & hit & (offset == OFF_CTRL) & mmio_byteenable[0];

  assign soft_start = ctrl_hit & ctrl_wr.soft_rst;
  assign clr_cnt    = ctrl_hit & ctrl_wr.clr_cnt;
  assign err_clr    = wr_acc & hit & (offset == OFF_ERR) & mmio_byteenable[0] & mmio_writedata[0];

  // Read mux is evaluated in the accept cycle so a read observes pre-write state.
  always_comb begin
    rd_mux           = '0;
    ctrl_rd          = '0;
    ctrl_rd.soft_rst = soft_reset;
    if (hit) begin
      case (offset)
        OFF_DFH:     rd_mux = dfh_pack(FEATURE_ID, FEATURE_REV, NEXT_DFH_OFFSET, END_OF_LIST);
        OFF_GUID_L:  rd_mux = GUID_L;
        OFF_GUID_H:  rd_mux = GUID_H;
        OFF_RSVD:    rd_mux = '0;
        OFF_SCRATCH: rd_mux = scratch;
        OFF_CTRL:    rd_mux = {62'h0, ctrl_rd};
        OFF_STATUS:  rd_mux = {rd_cnt, wr_cnt};
        OFF_ERR:     rd_mux = {63'h0, err};
        default:     rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge afu_clk or negedge afu_reset_n) begin
    if (!afu_reset_n) begin
      mmio_waitrequest   <= 1'b1;
      scratch            <= '0;
      wr_cnt             <= '0;
      rd_cnt             <= '0;
      err                <= 1'b0;
      valid_s1           <= 1'b0;
      data_s1            <= '0;
      mmio_readdatavalid <= 1'b0;
      mmio_readdata      <= '0;
    end else begin
      mmio_waitrequest <= 1'b0;

      if (wr_acc && hit && offset == OFF_SCRATCH) begin
        for (int b = 0; b < 8; b++) begin
          if (mmio_byteenable[b]) scratch[8*b +: 8] <= mmio_writedata[8*b +: 8];
        end
      end

      if (clr_cnt) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
      end else begin
        if (wr_acc) wr_cnt <= wr_cnt + 32'd1;
        if (rd_acc) rd_cnt <= rd_cnt + 32'd1;
      end

      // A new collision outranks a simultaneous write-1-to-clear.
      if (rd_acc && wr_acc) err <= 1'b1;
      else if (err_clr)     err <= 1'b0;

      valid_s1           <= rd_acc;
      data_s1            <= rd_acc ? rd_mux : '0;
      mmio_readdatavalid <= valid_s1;
      mmio_readdata      <= valid_s1 ? data_s1 : '0;
    end
  end

  asp_pulse_stretch #(
    .CYCLES(SOFT_RST_CYCLES)
  ) u_pulse (
    .afu_clk    (afu_clk),
    .afu_reset_n(afu_reset_n),
    .start      (soft_start),
    .pulse      (soft_reset)
  );

endmodule

`default_nettype wire

// File: tb/tb_asp_mmio_dfh_responder.sv
// +----------------------------------------------------------------------+
// | tb_asp_mmio_dfh_responder: scoreboard bench with directed and random  |
// | MMIO traffic against a behavioural register model.  Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_asp_mmio_dfh_responder;

  localparam logic [63:0] P_GUID_H = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] P_GUID_L = 64'h0123_4567_89AB_CDEF;
  localparam int          P_SR     = 16;

  logic        clk = 1'b0;
  logic        afu_reset_n = 1'b0;
  logic [15:0] mmio_address = '0;
  logic        mmio_read = 1'b0, mmio_write = 1'b0;
  logic [63:0] mmio_writedata = '0;
  logic [7:0]  mmio_byteenable = '0;
  logic        mmio_waitrequest, mmio_readdatavalid, soft_reset;
  logic [63:0] mmio_readdata;

  asp_mmio_dfh_responder #(
    .ADDR_WIDTH(16), .GUID_H(P_GUID_H), .GUID_L(P_GUID_L), .FEATURE_ID(12'h010),
    .FEATURE_REV(4'h0), .NEXT_DFH_OFFSET(24'h0), .END_OF_LIST(1'b1), .SOFT_RST_CYCLES(P_SR)
  ) dut (
    .afu_clk(clk), .afu_reset_n(afu_reset_n), .mmio_address(mmio_address),
    .mmio_read(mmio_read), .mmio_write(mmio_write), .mmio_writedata(mmio_writedata),
    .mmio_byteenable(mmio_byteenable), .mmio_waitrequest(mmio_waitrequest),
    .mmio_readdata(mmio_readdata), .mmio_readdatavalid(mmio_readdatavalid),
    .soft_reset(soft_reset)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;

  // Behavioural model state
  logic [63:0] m_scratch = '0;
  logic [31:0] m_wr = '0, m_rd = '0;
  bit          m_err = 0, m_ready = 0;
  int          m_sr = 0;
  logic [63:0] exp_q[$];
  int          stamp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_read(input logic [15:0] a);
    case (a)
      16'd0:   return 64'h1000_0100_0000_0010;
      16'd1:   return P_GUID_L;
      16'd2:   return P_GUID_H;
      16'd4:   return m_scratch;
      16'd5:   return {63'h0, m_sr > 0};
      16'd6:   return {m_rd, m_wr};
      16'd7:   return {63'h0, m_err};
      default: return 64'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_scratch = '0; m_wr = '0; m_rd = '0; m_err = 0; m_sr = 0; m_ready = 0;
    exp_q.delete(); stamp_q.delete();
  endtask

  // One clock cycle of stimulus; the model advances by exactly one edge.
  task automatic tick(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [63:0] d, input logic [7:0] be);
    bit acc, start, clr;
    logic [63:0] mask;
    mmio_read = rd; mmio_write = wr; mmio_address = a;
    mmio_writedata = d; mmio_byteenable = be;
    acc = m_ready; start = 0; clr = 0;
    if (acc && rd) begin
      exp_q.push_back(exp_read(a));
      stamp_q.push_back(cyc + 2);
    end
    if (acc && wr) begin
      if (a == 16'd4) begin
        mask = '0;
        for (int b = 0; b < 8; b++) if (be[b]) mask |= 64'hFF << (8 * b);
        m_scratch = (m_scratch & ~mask) | (d & mask);
      end
      if (a == 16'd5 && be[0]) begin start = d[0]; clr = d[1]; end
      if (a == 16'd7 && be[0] && d[0]) m_err = 0;
    end
    if (acc && rd && wr) m_err = 1;
    if (clr) begin
      m_wr = '0; m_rd = '0;
    end else if (acc) begin
      if (wr) m_wr = m_wr + 1;
      if (rd) m_rd = m_rd + 1;
    end
    @(posedge clk);
    if (!afu_reset_n) m_sr = 0;
    else if (start)   m_sr = P_SR;
    else if (m_sr > 0) m_sr--;
    m_ready = afu_reset_n;
    #1;
    mmio_read = 0; mmio_write = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 16'd0, 64'h0, 8'h00);
  endtask

  // Monitor: compares DUT responses against the scoreboard queue.
  always @(negedge clk) begin
    if (afu_reset_n) begin
      chk("waitrequest", {63'h0, mmio_waitrequest}, {63'h0, !m_ready});
      chk("soft_reset", {63'h0, soft_reset}, {63'h0, m_sr > 0});
      if (stamp_q.size() > 0 && stamp_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL missing_rdvalid: none at cycle %0d expected at %0d", cyc, stamp_q[0]);
        void'(exp_q.pop_front()); void'(stamp_q.pop_front());
      end
      if (mmio_readdatavalid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rdvalid: data %h at cycle %0d expected none", mmio_readdata, cyc);
        end else begin
          chk("rdata", mmio_readdata, exp_q.pop_front());
          chk("rd_latency", 64'(cyc), 64'(stamp_q.pop_front()));
        end
      end
    end
  end

  int n;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitrequest", {63'h0, mmio_waitrequest}, 64'h1);
    chk("rst_rdvalid", {63'h0, mmio_readdatavalid}, 64'h0);
    chk("rst_rdata", mmio_readdata, 64'h0);
    chk("rst_soft_reset", {63'h0, soft_reset}, 64'h0);
    afu_reset_n = 1;
    idle(2);

    // DFH / GUID / reserved
    tick(1, 0, 16'd0, 0, 0); tick(1, 0, 16'd1, 0, 0); tick(1, 0, 16'd2, 0, 0); tick(1, 0, 16'd3, 0, 0);
    idle(3);

    // Scratch partial write, read-after-write next cycle
    tick(0, 1, 16'd4, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F);
    tick(1, 0, 16'd4, 0, 0);
    idle(3);

    // Soft reset pulse and restart during pulse
    tick(0, 1, 16'd5, 64'h1, 8'h01);
    n = 0;
    while (soft_reset === 1'b1 && n < 100) begin n++; idle(1); end
    chk("pulse_len", 64'(n), 64'd16);
    tick(0, 1, 16'd5, 64'h1, 8'h01);
    n = 0;
    while (soft_reset === 1'b1 && n < 100) begin
      n++;
      if (n == 10) tick(0, 1, 16'd5, 64'h1, 8'h01);
      else idle(1);
    end
    chk("pulse_restart_len", 64'(n), 64'd26);
    tick(0, 1, 16'd5, 64'h1, 8'h00);  // CTRL with byteenable[0]=0 has no effect
    tick(1, 0, 16'd5, 0, 0);

    // Counters and clear
    tick(0, 1, 16'd5, 64'h2, 8'h01);
    tick(0, 1, 16'd4, 0, 8'h00); tick(0, 1, 16'd4, 0, 8'h00); tick(0, 1, 16'd9, 64'h1, 8'hFF);
    tick(1, 0, 16'd3, 0, 0); tick(1, 0, 16'd3, 0, 0);
    tick(1, 0, 16'd6, 0, 0);
    tick(0, 1, 16'd5, 64'h2, 8'h01);
    tick(1, 0, 16'd6, 0, 0);
    idle(3);

    // Read/write collision, ERR set and W1C
    tick(0, 1, 16'd4, 64'h0, 8'hFF);
    tick(1, 1, 16'd4, 64'h5, 8'hFF);
    tick(1, 0, 16'd4, 0, 0);
    tick(1, 0, 16'd7, 0, 0);
    tick(0, 1, 16'd7, 64'h1, 8'h01);
    tick(1, 0, 16'd7, 0, 0);
    tick(1, 1, 16'd7, 64'h1, 8'h01);  // collision outranks W1C
    tick(1, 0, 16'd7, 0, 0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom), 1'($urandom), 16'($urandom_range(0, 9)),
           {$urandom, $urandom}, 8'($urandom));
    end
    idle(4);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of back-to-back reads and an active pulse
    tick(0, 1, 16'd5, 64'h1, 8'h01);
    tick(1, 0, 16'd0, 0, 0); tick(1, 0, 16'd1, 0, 0); tick(1, 0, 16'd2, 0, 0);
    mmio_read = 1; mmio_address = 16'd3;
    @(negedge clk); #1;
    afu_reset_n = 0;
    model_reset();
    #1;
    chk("mid_rst_waitrequest", {63'h0, mmio_waitrequest}, 64'h1);
    chk("mid_rst_rdvalid", {63'h0, mmio_readdatavalid}, 64'h0);
    chk("mid_rst_rdata", mmio_readdata, 64'h0);
    chk("mid_rst_soft_reset", {63'h0, soft_reset}, 64'h0);
    mmio_read = 0;
    idle(3);
    afu_reset_n = 1;
    chk("release_waitrequest", {63'h0, mmio_waitrequest}, 64'h1);
    idle(4);
    tick(1, 0, 16'd4, 0, 0); tick(1, 0, 16'd6, 0, 0); tick(1, 0, 16'd7, 0, 0);
    idle(4);
    chk("final_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
